// File: rtl/id_stage.sv
// id_stage: IF/ID register + decode; define ID_INTERLOCK_EN to add the load-use interlock stall.
// Latency 1 cycle after IF/ID capture; iExEn=0 freezes all state, iBrTaken squashes IF/ID and output.
module id_stage #(
  parameter int OPC_W = 6,
  parameter int ARG_W = 10,
  parameter int PC_W  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OPC_W+ARG_W-1:0] iInstr,
  input  logic [PC_W-1:0]        iNewPc,
  input  logic                   iExEn,
  input  logic                   iBrTaken,
  output logic                   oFetchEn,
  output logic [PC_W-1:0]        oBrDir,
  output logic                   oValid,
  output logic [OPC_W-1:0]       oOpcode,
  output logic [ARG_W-1:0]       oArg,
  output logic [PC_W-1:0]        oPc,
  output logic                   oWrA,
  output logic                   oWrB,
  output logic                   oMemRd,
  output logic                   oMemWr,
  output logic                   oIsBranch
);
  localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDCA  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LDCB  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDA   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_LDB   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_STA   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STB   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_ADDA  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_ADDB  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SUBA  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_SUBB  = OPC_W'(10);
  // Branch family occupies 0x10-0x1F (BAEQ=0x10, BACS=0x11, BBEQ=0x18, BBCS=0x19); bit 3 selects B flags.
  localparam logic [OPC_W-1:0] OP_BR_LO = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_BR_HI = OPC_W'(31);

  typedef struct packed {
    logic             vld;
    logic [OPC_W-1:0] opc;
    logic [ARG_W-1:0] arg;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  br_dir;
    logic             wr_a;
    logic             wr_b;
    logic             mem_rd;
    logic             mem_wr;
    logic             is_br;
  } out_t;

  logic [OPC_W+ARG_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]        ifid_pc_q, ifid_pc_d;
  logic                   ifid_vld_q, ifid_vld_d;
  out_t                   out_q, out_d, dec, bub;
  logic [OPC_W-1:0]       ifid_opc;
  logic [ARG_W-1:0]       ifid_arg;
  logic                   rd_a, rd_b, ld_a, ld_b, stall, advance;

  assign ifid_opc = ifid_instr_q[OPC_W+ARG_W-1:ARG_W];
  assign ifid_arg = ifid_instr_q[ARG_W-1:0];

  always_comb begin
    dec        = '0;
    dec.vld    = ifid_vld_q;
    dec.opc    = OP_NOP;
    dec.arg    = ifid_arg;
    dec.pc     = ifid_pc_q;
    dec.br_dir = ifid_pc_q + PC_W'(ifid_arg[5:0]);
    rd_a = 1'b0;
    rd_b = 1'b0;
    ld_a = 1'b0;
    ld_b = 1'b0;
    case (ifid_opc)
      OP_LDCA: begin dec.opc = ifid_opc; dec.wr_a = 1'b1; ld_a = 1'b1; end
      OP_LDCB: begin dec.opc = ifid_opc; dec.wr_b = 1'b1; ld_b = 1'b1; end
      OP_LDA:  begin dec.opc = ifid_opc; dec.wr_a = 1'b1; dec.mem_rd = 1'b1; ld_a = 1'b1; end
      OP_LDB:  begin dec.opc = ifid_opc; dec.wr_b = 1'b1; dec.mem_rd = 1'b1; ld_b = 1'b1; end
      OP_STA:  begin dec.opc = ifid_opc; dec.mem_wr = 1'b1; rd_a = 1'b1; end
      OP_STB:  begin dec.opc = ifid_opc; dec.mem_wr = 1'b1; rd_b = 1'b1; end
      OP_ADDA, OP_SUBA: begin dec.opc = ifid_opc; dec.wr_a = 1'b1; rd_a = 1'b1; rd_b = 1'b1; end
      OP_ADDB, OP_SUBB: begin dec.opc = ifid_opc; dec.wr_b = 1'b1; rd_a = 1'b1; rd_b = 1'b1; end
      default: begin
        if (ifid_opc >= OP_BR_LO && ifid_opc <= OP_BR_HI) begin
          dec.opc   = ifid_opc;
          dec.is_br = 1'b1;
          rd_a      = !ifid_opc[3];
          rd_b      = ifid_opc[3];
        end
      end
    endcase
  end

`ifdef ID_INTERLOCK_EN
  logic [1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  assign stall = (rd_a && cnt_a_q != 2'd0) || (rd_b && cnt_b_q != 2'd0);

  // Counters tick on every enabled cycle, flushed or not; an issuing load re-arms them.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (iExEn && cnt_a_q != 2'd0) cnt_a_d = cnt_a_q - 2'd1;
    if (iExEn && cnt_b_q != 2'd0) cnt_b_d = cnt_b_q - 2'd1;
    if (advance && ld_a) cnt_a_d = 2'd2;
    if (advance && ld_b) cnt_b_d = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a_q <= 2'd0;
      cnt_b_q <= 2'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end
`else
  logic unused_hazard;
  assign unused_hazard = ^{rd_a, rd_b, ld_a, ld_b};
  assign stall = 1'b0;
`endif

  assign advance  = iExEn && !stall && !iBrTaken;
  assign oFetchEn = reset || iBrTaken || (iExEn && !stall);

  always_comb begin
    bub        = out_q;
    bub.vld    = 1'b0;
    bub.opc    = OP_NOP;
    bub.wr_a   = 1'b0;
    bub.wr_b   = 1'b0;
    bub.mem_rd = 1'b0;
    bub.mem_wr = 1'b0;
    bub.is_br  = 1'b0;
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_vld_d   = ifid_vld_q;
    out_d        = out_q;
    if (iBrTaken) begin
      ifid_instr_d = {OP_NOP, {ARG_W{1'b0}}};
      ifid_vld_d   = 1'b0;
      out_d        = bub;
    end else if (iExEn) begin
      if (stall) begin
        out_d = bub;
      end else begin
        ifid_instr_d = iInstr;
        ifid_pc_d    = iNewPc;
        ifid_vld_d   = 1'b1;
        out_d        = dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_q <= {OP_NOP, {ARG_W{1'b0}}};
      ifid_pc_q    <= '0;
      ifid_vld_q   <= 1'b0;
      out_q        <= '0;
      out_q.opc    <= OP_NOP;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_vld_q   <= ifid_vld_d;
      out_q        <= out_d;
    end
  end

  assign oValid    = out_q.vld;
  assign oOpcode   = out_q.opc;
  assign oArg      = out_q.arg;
  assign oPc       = out_q.pc;
  assign oBrDir    = out_q.br_dir;
  assign oWrA      = out_q.wr_a;
  assign oWrB      = out_q.wr_b;
  assign oMemRd    = out_q.mem_rd;
  assign oMemWr    = out_q.mem_wr;
  assign oIsBranch = out_q.is_br;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage; expectations follow ID_INTERLOCK_EN when it is defined.
module tb_id_stage;
  localparam int OPC_W = 6;
  localparam int ARG_W = 10;
  localparam int PC_W  = 10;

  localparam logic [5:0] NOP  = 6'd0;
  localparam logic [5:0] LDCA = 6'd1;
  localparam logic [5:0] LDCB = 6'd2;
  localparam logic [5:0] LDA  = 6'd3;
  localparam logic [5:0] LDB  = 6'd4;
  localparam logic [5:0] STA  = 6'd5;
  localparam logic [5:0] STB  = 6'd6;
  localparam logic [5:0] ADDA = 6'd7;
  localparam logic [5:0] BAEQ = 6'd16;
  localparam logic [5:0] BBEQ = 6'd24;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [OPC_W+ARG_W-1:0] iInstr;
  logic [PC_W-1:0]        iNewPc;
  logic                   iExEn;
  logic                   iBrTaken;
  logic                   oFetchEn;
  logic [PC_W-1:0]        oBrDir;
  logic                   oValid;
  logic [OPC_W-1:0]       oOpcode;
  logic [ARG_W-1:0]       oArg;
  logic [PC_W-1:0]        oPc;
  logic                   oWrA, oWrB, oMemRd, oMemWr, oIsBranch;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage #(.OPC_W(OPC_W), .ARG_W(ARG_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .iInstr(iInstr), .iNewPc(iNewPc), .iExEn(iExEn),
    .iBrTaken(iBrTaken), .oFetchEn(oFetchEn), .oBrDir(oBrDir), .oValid(oValid),
    .oOpcode(oOpcode), .oArg(oArg), .oPc(oPc), .oWrA(oWrA), .oWrB(oWrB),
    .oMemRd(oMemRd), .oMemWr(oMemWr), .oIsBranch(oIsBranch)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [5:0] op, input logic [9:0] arg, input logic [9:0] pc);
    iInstr = {op, arg};
    iNewPc = pc;
  endtask

  initial begin
    reset = 1'b1; iExEn = 1'b1; iBrTaken = 1'b0;
    fetch(LDCA, 10'h005, 10'd1);
    step(); step();
    chk("rst_valid", 32'(oValid), 0);
    chk("rst_opcode", 32'(oOpcode), 32'(NOP));
    chk("rst_pc", 32'(oPc), 0);
    chk("rst_brdir", 32'(oBrDir), 0);
    chk("rst_wra", 32'(oWrA), 0);
    chk("rst_fetch_en", 32'(oFetchEn), 1);
    reset = 1'b0;
    step();
    chk("first_bubble", 32'(oValid), 0);
    fetch(LDCB, 10'd7, 10'd2);
    step();
    chk("ldca_valid", 32'(oValid), 1);
    chk("ldca_wra", 32'(oWrA), 1);
    chk("ldca_arg", 32'(oArg), 5);
    chk("ldca_pc", 32'(oPc), 1);
    chk("ldca_memrd", 32'(oMemRd), 0);
    fetch(ADDA, 10'd0, 10'd3);
    step();
    chk("ldcb_wrb", 32'(oWrB), 1);
    fetch(NOP, 10'd0, 10'd4);
    #1;
`ifdef ID_INTERLOCK_EN
    chk("hz_fetch_en0", 32'(oFetchEn), 0);
    step();
    chk("hz_bubble1", 32'(oValid), 0);
    chk("hz_bubble1_wra", 32'(oWrA), 0);
    iExEn = 1'b0; #1;
    chk("frz_fetch_en", 32'(oFetchEn), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_valid", 32'(oValid), 0);
      chk("frz_opcode", 32'(oOpcode), 32'(NOP));
    end
    iExEn = 1'b1; #1;
    chk("hz_fetch_en1", 32'(oFetchEn), 0);
    step();
    chk("hz_bubble2", 32'(oValid), 0);
    chk("hz_fetch_en2", 32'(oFetchEn), 1);
    step();
    chk("adda_valid", 32'(oValid), 1);
    chk("adda_opcode", 32'(oOpcode), 32'(ADDA));
    chk("adda_wra", 32'(oWrA), 1);
    chk("adda_pc", 32'(oPc), 3);
`else
    chk("nohz_fetch_en", 32'(oFetchEn), 1);
    step();
    chk("adda_valid", 32'(oValid), 1);
    chk("adda_opcode", 32'(oOpcode), 32'(ADDA));
    chk("adda_wra", 32'(oWrA), 1);
    chk("adda_pc", 32'(oPc), 3);
    iExEn = 1'b0; #1;
    chk("frz_fetch_en", 32'(oFetchEn), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_opcode", 32'(oOpcode), 32'(ADDA));
      chk("frz_pc", 32'(oPc), 3);
    end
    iExEn = 1'b1;
`endif
    fetch(STB, 10'h050, 10'd5);
    step();
    chk("nop_valid", 32'(oValid), 1);
    chk("nop_opcode", 32'(oOpcode), 32'(NOP));
    chk("nop_pc", 32'(oPc), 4);
    fetch(BBEQ, 10'd48, 10'd14);
    step();
    chk("stb_memwr", 32'(oMemWr), 1);
    chk("stb_memrd", 32'(oMemRd), 0);
    chk("stb_wr", 32'({oWrA, oWrB}), 0);
    chk("stb_arg", 32'(oArg), 32'h050);
    fetch(LDA, 10'd1, 10'd15);
    step();
    chk("bbeq_isbr", 32'(oIsBranch), 1);
    chk("bbeq_brdir", 32'(oBrDir), 62);
    chk("bbeq_pc", 32'(oPc), 14);
    iBrTaken = 1'b1;
    fetch(LDB, 10'd2, 10'd16);
    #1;
    chk("flush_fetch_en", 32'(oFetchEn), 1);
    step();
    chk("flush_valid", 32'(oValid), 0);
    chk("flush_memrd", 32'(oMemRd), 0);
    iBrTaken = 1'b0;
    fetch(BAEQ, 10'h03F, 10'd1020);
    step();
    chk("flush_valid2", 32'(oValid), 0);
    fetch(NOP, 10'd0, 10'd1021);
    step();
    chk("wrap_isbr", 32'(oIsBranch), 1);
    chk("wrap_brdir", 32'(oBrDir), 59);
    chk("wrap_pc", 32'(oPc), 1020);
    fetch(LDA, 10'd3, 10'd30);
    step();
    fetch(LDCA, 10'd4, 10'd31);
    step();
    chk("lda_memrd", 32'(oMemRd), 1);
    chk("lda_wra", 32'(oWrA), 1);
    fetch(STA, 10'd9, 10'd32);
    step();
    chk("ldca2_wra", 32'(oWrA), 1);
    chk("ldca2_memrd", 32'(oMemRd), 0);
    fetch(NOP, 10'd0, 10'd33);
`ifdef ID_INTERLOCK_EN
    step();
    chk("reload_bubble1", 32'(oValid), 0);
    step();
    chk("reload_bubble2", 32'(oValid), 0);
`endif
    step();
    chk("sta_memwr", 32'(oMemWr), 1);
    chk("sta_pc", 32'(oPc), 32);
    fetch(LDB, 10'd1, 10'd40);
    step();
    fetch(STB, 10'd2, 10'd41);
    step();
    chk("ldb_memrd", 32'(oMemRd), 1);
`ifdef ID_INTERLOCK_EN
    chk("ldb_use_fetch_en", 32'(oFetchEn), 0);
`else
    chk("ldb_use_fetch_en", 32'(oFetchEn), 1);
`endif
    reset = 1'b1;
    step();
    chk("midrst_valid", 32'(oValid), 0);
    chk("midrst_fetch_en", 32'(oFetchEn), 1);
    reset = 1'b0; #1;
    chk("rst_release_fetch_en", 32'(oFetchEn), 1);
    step();
    chk("post_rst_bubble", 32'(oValid), 0);
    step();
    chk("post_rst_stb_valid", 32'(oValid), 1);
    chk("post_rst_stb_memwr", 32'(oMemWr), 1);
    chk("post_rst_stb_pc", 32'(oPc), 41);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
